ldl_hs_ctrl: RTL and testbench
==============================

LDL_HS_CTRL -- requirements
Module: ldl_hs_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent handshake channels, 1..32.
REQ-002 SHALL have parameter SYNC, default 2: synchroniser stages on req/latched, 0 or 2.
REQ-003 SHALL have parameter TMO_W, default 8: timeout counter width in bits.
REQ-004 SHALL have parameter TMO, default 200: cycles allowed in ASK state; 0 disables timeout.
REQ-005 SHALL have port wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req  in  NCH  per-channel 4-phase request from the producer.
REQ-008 SHALL have port latched  in  NCH  per-channel indication that the data latch has captured.
REQ-009 SHALL have port err_clr  in  NCH  per-channel one-cycle clear of the sticky error.
REQ-010 SHALL have port ask  out  NCH  per-channel request to the latch to capture.
REQ-011 SHALL have port ack  out  NCH  per-channel acknowledge to the producer.
REQ-012 SHALL have port err  out  NCH  per-channel sticky timeout error.
REQ-013 SHALL have port done  out  NCH  per-channel one-cycle pulse on handshake completion.

Function
REQ-014 SHALL, for SYNC=2, pass req and latched through two flops per bit before use; for SYNC=0, use them directly. "req_s"/"lat_s" below mean the values after this stage.
REQ-015 SHALL run one FSM per channel with states IDLE, ASK, ACK, REL and ERR, fully independent across channels.
REQ-016 SHALL decode outputs from registered state only: ask=1 in ASK; ack=1 in ACK and REL; otherwise both 0.
REQ-017 SHALL move IDLE->ASK when req_s=1 and lat_s=0; with req_s=1 and lat_s=1 it SHALL stay in IDLE until lat_s=0.
REQ-018 SHALL move ASK->ACK when lat_s=1.
REQ-019 SHALL move ASK->IDLE when req_s=0 and lat_s=0 (producer abort); no error and no done.
REQ-020 SHALL, in ASK, increment a per-channel TMO_W-bit counter each cycle. Entry to ASK loads 0. When TMO!=0 and the counter equals TMO-1 with lat_s still 0, the FSM SHALL go to ERR.
REQ-021 SHALL take priority lat_s=1 over timeout when both occur in the same cycle.
REQ-022 SHALL set err[i] on entry to ERR; ERR SHALL go to IDLE when req_s=0.
REQ-023 SHALL move ACK->REL when req_s=0.
REQ-024 SHALL move REL->IDLE when lat_s=0, and assert done[i] for exactly the first cycle back in IDLE.
REQ-025 SHALL clear err[i] on err_clr[i]=1; a set in the same cycle SHALL win over the clear.
REQ-026 SHALL have latency, for SYNC=0, of one cycle from a sampled req_s/lat_s change to the resulting output change; SYNC=2 adds two cycles.
REQ-027 SHALL never assert ask[i] and ack[i] in the same cycle.
REQ-028 SHALL hold the timeout counter without wrap. TMO SHALL satisfy TMO < 2**TMO_W, checked at elaboration.

Reset
REQ-029 SHALL, while wb_rst_i=1 at a clock edge, force every FSM to IDLE and set ask, ack, err, done, the counters and the synchroniser flops to 0.
REQ-030 SHALL, on reset mid-handshake, deassert ask/ack at the next edge. After release, a channel with req still high SHALL restart from IDLE per REQ-017.
REQ-031 SHALL have reset override err_clr and all FSM transitions.

Verification
REQ-032 Nominal, SYNC=0, NCH=1: req=1 @c0 -> ask=1 @c1; latched=1 @c3 -> ask=0, ack=1 @c4; req=0 @c6 -> REL; latched=0 @c8 -> ack=0 and done=1 @c9, done=0 @c10.
REQ-033 Timeout, TMO=5, SYNC=0: req=1, latched held 0 -> ask high for exactly 5 cycles, then err=1 and ask=0. After req=0: IDLE, err stays 1. err_clr pulse -> err=0 next cycle.
REQ-034 Simultaneous events, TMO=5: latched=1 on the 5th ASK cycle -> ACK, err=0. Separately, err_clr=1 on the same cycle as a new timeout -> err=1.
REQ-035 Independence, NCH=4: channels 0 and 2 complete overlapping handshakes with different timings while channel 3 times out. Each channel's ask/ack/done/err matches its single-channel trace; channel 1 stays 0.
REQ-036 Reset mid-operation, SYNC=2: assert wb_rst_i during ACK with req=1 -> ack=0 next edge. Release reset with req=1 and latched=0 -> ask=1 exactly 3 cycles after release.
REQ-037 Abort: req=1 then req=0 before latched while in ASK -> back to IDLE; no ack, no done, no err. Check ask/ack mutual exclusion throughout all scenarios.

Source files
------------

// File: rtl/ldl_hs_ctrl.sv
// rtl/ldl_hs_ctrl.sv - per-channel 4-phase req/latch handshake controller
// Each channel: IDLE->ASK->ACK->REL->IDLE, with an ASK timeout into a sticky-error state.
module ldl_hs_ctrl #(
  parameter int NCH   = 4,
  parameter int SYNC  = 2,
  parameter int TMO_W = 8,
  parameter int TMO   = 200
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] latched,
  input  logic [NCH-1:0] err_clr,
  output logic [NCH-1:0] ask,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] err,
  output logic [NCH-1:0] done
);

  if (!(TMO < 2**TMO_W)) begin : g_bad_tmo
    $error("ldl_hs_ctrl: TMO must be < 2**TMO_W");
  end
  if (SYNC != 0 && SYNC != 2) begin : g_bad_sync
    $error("ldl_hs_ctrl: SYNC must be 0 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_ASK, S_ACK, S_REL, S_ERR} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = (TMO == 0) ? '0 : TMO_W'(TMO - 1);

  logic [NCH-1:0] req_s, lat_s;

  if (SYNC == 2) begin : g_sync
    logic [NCH-1:0] req_m_q, req_s_q, lat_m_q, lat_s_q;
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        req_m_q <= '0;
        req_s_q <= '0;
        lat_m_q <= '0;
        lat_s_q <= '0;
      end else begin
        req_m_q <= req;
        req_s_q <= req_m_q;
        lat_m_q <= latched;
        lat_s_q <= lat_m_q;
      end
    end
    assign req_s = req_s_q;
    assign lat_s = lat_s_q;
  end else begin : g_nosync
    assign req_s = req;
    assign lat_s = latched;
  end

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [TMO_W-1:0] cnt_q [NCH];
  logic [TMO_W-1:0] cnt_d [NCH];
  logic [NCH-1:0] ask_q, ask_d, ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic [NCH-1:0] err_set;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      done_d[i]  = 1'b0;
      err_set[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (req_s[i] && !lat_s[i]) begin
            state_d[i] = S_ASK;
            cnt_d[i]   = '0;
          end
        end
        S_ASK: begin
          // Saturating count; a captured latch outranks both abort and timeout.
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + TMO_W'(1);
          if (lat_s[i]) begin
            state_d[i] = S_ACK;
          end else if (!req_s[i]) begin
            state_d[i] = S_IDLE;
          end else if (TMO != 0 && cnt_q[i] == TMO_LAST) begin
            state_d[i] = S_ERR;
            err_set[i] = 1'b1;
          end
        end
        S_ACK: if (!req_s[i]) state_d[i] = S_REL;
        S_REL: begin
          if (!lat_s[i]) begin
            state_d[i] = S_IDLE;
            done_d[i]  = 1'b1;
          end
        end
        S_ERR:   if (!req_s[i]) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
      ask_d[i] = (state_d[i] == S_ASK);
      ack_d[i] = (state_d[i] == S_ACK) || (state_d[i] == S_REL);
      err_d[i] = err_set[i] | (err_q[i] & ~err_clr[i]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      ask_q  <= '0;
      ack_q  <= '0;
      err_q  <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ask_q  <= ask_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign ask  = ask_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign done = done_q;

endmodule

// File: tb/tb_ldl_hs_ctrl.sv
// tb/tb_ldl_hs_ctrl.sv - directed scoreboard bench for ldl_hs_ctrl
// DUT A: NCH=4, SYNC=0, TMO=5.  DUT B: NCH=1, SYNC=2, default TMO.
module tb_ldl_hs_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, b_rst;
  logic [3:0] a_req, a_lat, a_clr, a_ask, a_ack, a_err, a_done;
  logic [0:0] b_req, b_lat, b_clr, b_ask, b_ack, b_err, b_done;

  ldl_hs_ctrl #(.NCH(4), .SYNC(0), .TMO_W(8), .TMO(5)) u_a (
    .wb_clk_i(clk), .wb_rst_i(a_rst), .req(a_req), .latched(a_lat), .err_clr(a_clr),
    .ask(a_ask), .ack(a_ack), .err(a_err), .done(a_done)
  );

  ldl_hs_ctrl #(.NCH(1), .SYNC(2)) u_b (
    .wb_clk_i(clk), .wb_rst_i(b_rst), .req(b_req), .latched(b_lat), .err_clr(b_clr),
    .ask(b_ask), .ack(b_ack), .err(b_err), .done(b_done)
  );

  typedef struct {
    string      tag;
    logic [3:0] ask, ack, err, done;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic [3:0] ea_ask = '0, ea_ack = '0, ea_err = '0, ea_done = '0;
  logic       eb_ask = 1'b0, eb_ack = 1'b0, eb_err = 1'b0, eb_done = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ea(input logic [3:0] k, input logic [3:0] c, input logic [3:0] e, input logic [3:0] d);
    ea_ask = k; ea_ack = c; ea_err = e; ea_done = d;
  endtask

  // Push expectation for the state after the coming edge, then compare once it lands.
  task automatic step(input string tag);
    exp_t e;
    e.tag = tag; e.ask = ea_ask; e.ack = ea_ack; e.err = ea_err; e.done = ea_done;
    e.b = {eb_ask, eb_ack, eb_err, eb_done};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " a"}, {a_ask, a_ack, a_err, a_done}, {e.ask, e.ack, e.err, e.done});
    chk({e.tag, " b"}, {12'h0, b_ask, b_ack, b_err, b_done}, {12'h0, e.b});
    chk({e.tag, " mutex"}, {11'h0, b_ask & b_ack, a_ask & a_ack}, 16'h0);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req = '0; a_lat = '0; a_clr = '0;
    b_req = '0; b_lat = '0; b_clr = '0;
    step("rst0");
    step("rst1");
    a_rst = 1'b0; b_rst = 1'b0;

    // nominal handshake on channel 0
    a_req = 4'b0001; ea(4'b0001, 0, 0, 0);
    step("nom_ask0"); step("nom_ask1"); step("nom_ask2");
    a_lat = 4'b0001; ea(0, 4'b0001, 0, 0);
    step("nom_ack0"); step("nom_ack1");
    a_req = 4'b0000;
    step("nom_rel0"); step("nom_rel1");
    a_lat = 4'b0000; ea(0, 0, 0, 4'b0001);
    step("nom_done");
    ea(0, 0, 0, 0);
    step("nom_idle");

    // timeout: exactly five ASK cycles, then sticky error
    a_req = 4'b0001; ea(4'b0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("tmo_ask");
    ea(0, 0, 4'b0001, 0);
    step("tmo_err"); step("tmo_err_hold");
    a_req = 4'b0000;
    step("tmo_idle"); step("tmo_idle2");

    // new timeout coinciding with err_clr: set wins
    a_req = 4'b0001; ea(4'b0001, 0, 4'b0001, 0);
    for (int i = 0; i < 5; i++) step("cs_ask");
    a_clr = 4'b0001; ea(0, 0, 4'b0001, 0);
    step("cs_set_wins");
    a_clr = 4'b0000; a_req = 4'b0000;
    step("cs_idle");
    a_clr = 4'b0001; ea(0, 0, 0, 0);
    step("cs_clr");
    a_clr = 4'b0000;
    step("cs_clr_idle");

    // latch on the would-be timeout cycle: ACK, no error
    a_req = 4'b0001; ea(4'b0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("sim_ask");
    a_lat = 4'b0001; ea(0, 4'b0001, 0, 0);
    step("sim_ack");
    a_req = 4'b0000;
    step("sim_rel");
    a_lat = 4'b0000; ea(0, 0, 0, 4'b0001);
    step("sim_done");
    ea(0, 0, 0, 0);
    step("sim_idle");

    // abort on channel 1
    a_req = 4'b0010; ea(4'b0010, 0, 0, 0);
    step("ab_ask0"); step("ab_ask1");
    a_req = 4'b0000; ea(0, 0, 0, 0);
    step("ab_idle0"); step("ab_idle1");

    // independence: ch0 and ch2 complete, ch3 times out, ch1 idle
    a_req = 4'b1001; ea(4'b1001, 4'b0000, 4'b0000, 4'b0000); step("ind1");
    a_req = 4'b1101; ea(4'b1101, 4'b0000, 4'b0000, 4'b0000); step("ind2");
    a_lat = 4'b0001; ea(4'b1100, 4'b0001, 4'b0000, 4'b0000); step("ind3");
    a_req = 4'b1100; ea(4'b1100, 4'b0001, 4'b0000, 4'b0000); step("ind4");
    a_lat = 4'b0101; ea(4'b1000, 4'b0101, 4'b0000, 4'b0000); step("ind5");
    a_lat = 4'b0100; ea(4'b0000, 4'b0100, 4'b1000, 4'b0001); step("ind6");
    a_req = 4'b1000; ea(4'b0000, 4'b0100, 4'b1000, 4'b0000); step("ind7");
    a_lat = 4'b0000; ea(4'b0000, 4'b0000, 4'b1000, 4'b0100); step("ind8");
    a_req = 4'b0000; ea(4'b0000, 4'b0000, 4'b1000, 4'b0000); step("ind9");
    a_clr = 4'b1000; ea(0, 0, 0, 0); step("ind_clr");
    a_clr = 4'b0000;

    // reset during ACK on DUT A, restart with req still high
    a_req = 4'b0001; ea(4'b0001, 0, 0, 0); step("ra_ask");
    a_lat = 4'b0001; ea(0, 4'b0001, 0, 0); step("ra_ack");
    a_rst = 1'b1; ea(0, 0, 0, 0); step("ra_rst");
    a_rst = 1'b0; a_lat = 4'b0000; ea(4'b0001, 0, 0, 0); step("ra_restart");
    a_req = 4'b0000; ea(0, 0, 0, 0); step("ra_idle");

    // DUT B: two-stage sync adds two cycles
    b_req = 1'b1;
    step("b_sync0"); step("b_sync1");
    eb_ask = 1'b1; step("b_ask");
    b_lat = 1'b1;
    step("b_ask_hold0"); step("b_ask_hold1");
    eb_ask = 1'b0; eb_ack = 1'b1; step("b_ack");
    b_rst = 1'b1; eb_ack = 1'b0; step("b_rst");
    b_rst = 1'b0; b_lat = 1'b0;
    step("b_rel0"); step("b_rel1");
    eb_ask = 1'b1; step("b_restart_ask");
    b_req = 1'b0;
    step("b_abort0"); step("b_abort1");
    eb_ask = 1'b0; step("b_abort_idle");
    step("b_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
